output_drain_ctrl: RTL and testbench
====================================

# output_drain_ctrl

Sequencer that empties the eight accumulated output registers of the convolution output collector and returns it to collecting. It watches the collector's `res_valid`/`full_flag`, streams the valid registers out as fixed-width beats over a valid/ready handshake, then issues a `WRITE` op to clear the collector. It also gates the op stream and stalls the adder tree while a drain is in progress.

## Interface
- `DATA_WIDTH`, 32: bits per word.
- `DATA_OF_SET`, 128: words per output register.
- `LANES`, 8: words per output beat; must divide `DATA_OF_SET`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `op_in`  in  accel_op_e  op from the dispatcher.
- `flush_req`  in  1  single-cycle request to drain a partially filled collector.
- `res`  in  [7:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0]  collector output registers.
- `res_valid`  in  8  per-register valid; fills contiguously from bit 0.
- `full_flag`  in  1  collector full.
- `op_out`  out  accel_op_e  op forwarded to the collector.
- `adder_stall`  out  1  holds the adder tree.
- `out_data`  out  [LANES-1:0][DATA_WIDTH-1:0]  beat payload.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink ready.
- `out_last`  out  1  final beat of the drain.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse on drain completion.
- `stall_cnt`  out  32  backpressure cycle count (see Configuration).

## Operation
- FSM states: IDLE, DRAIN, CLEAR, SETTLE.
- IDLE → DRAIN when `full_flag`, or when `flush_req` is high and `res_valid != 0`. On this transition:
  - latch `last_reg` = index of the highest set `res_valid` bit;
  - set `reg_idx` = 0 and `beat_idx` = 0.
- IDLE → CLEAR when `flush_req` is high and `res_valid == 0`. No beats are sent and `done` still pulses.
- DRAIN behaviour:
  - `out_valid` = 1.
  - `out_data` = `res[reg_idx][beat_idx*LANES +: LANES]`.
  - A beat transfers on `out_valid & out_ready`. On transfer, `beat_idx` increments. It wraps at `DATA_OF_SET/LANES - 1`, and on wrap `reg_idx` increments.
  - `out_last` = (`reg_idx == last_reg`) & (final beat).
  - A transfer with `out_last` moves the FSM to CLEAR.
- CLEAR: `op_out` = `WRITE` for exactly one cycle, then go to SETTLE. The collector registers the op, so it clears one cycle later.
- SETTLE: one cycle, `done` = 1, then go to IDLE.
- `op_out` = `op_in` in IDLE; `NONE` in DRAIN and SETTLE; `WRITE` in CLEAR.
- `adder_stall` = `busy | full_flag`. This freezes `res` during DRAIN, including partial flushes.
- `flush_req` while `busy` is ignored, not queued.
- `out_data` and `out_last` must stay stable while `out_valid & !out_ready`.
- Widths:
  - `reg_idx`: 3 bits.
  - `beat_idx`: `$clog2(DATA_OF_SET/LANES)` bits.
  - `stall_cnt` saturates at all-ones.

## Timing
- Reset values:
  - state IDLE; `out_valid`, `out_last`, `done`, `busy` = 0;
  - `op_out` = `NONE`; `adder_stall` = 0; `stall_cnt` = 0.
- Reset mid-drain aborts immediately. The next drain restarts at register 0, beat 0.
- First beat is valid one cycle after the triggering edge.
- With `out_ready` held high, a full drain takes 8·(DATA_OF_SET/LANES) beat cycles, plus 1 CLEAR cycle, plus 1 SETTLE cycle.
- `out_valid` is registered. `out_data` is muxed from registered indices, so there is no combinational path from `out_ready` to `out_valid`.
- A `full_flag` deassertion during DRAIN is ignored. `last_reg` is already latched.

## Configuration
- `ODC_PERF_CNT_EN` defined: `stall_cnt` increments every cycle with `out_valid & !out_ready`. It clears only on `rst`.
- `ODC_PERF_CNT_EN` undefined: no counter logic; `stall_cnt` is tied to 0.

## Structure
- `accel_op_e` (`NONE`, `WRITE`, …) comes from `ara_pkg`.
- Add the FSM enum `odc_state_e` to `ara_pkg`.
- One sub-module, `odc_beat_sel`: a combinational mux that selects the `LANES` words from `res` using `reg_idx`/`beat_idx`.

## Test plan
- Full drain: set `res[i][w] = i*256+w`, all `res_valid` = 8'hFF, `full_flag` = 1, `out_ready` = 1.
  - Expect 128 beats; beat k carries words from `res[k/16]`, beginning at word (k%16)·8.
  - `out_last` on beat 127; `op_out` = `WRITE` for 1 cycle; `done` 2 cycles after the last beat.
- Partial flush: `res_valid` = 8'h07 and a `flush_req` pulse.
  - Expect 48 beats, `out_last` on beat 47, and `adder_stall` high throughout.
- Empty flush: `res_valid` = 0 and a `flush_req` pulse.
  - Expect no `out_valid`, `WRITE` on the next cycle, and `done` the cycle after.
- Backpressure: toggle `out_ready` 1/0 every cycle during a full drain.
  - Data stays stable while stalled; exactly 128 transfers occur.
  - With `ODC_PERF_CNT_EN` defined, `stall_cnt` = 128.
- Reset mid-drain: assert `rst` at beat 40.
  - All outputs go to their reset values.
  - A new `full_flag` restarts the drain at `res[0]` word 0.
- Op gating: `op_in` = `WRITE` during DRAIN → `op_out` = `NONE`. In IDLE, `op_out` follows `op_in` in the same cycle.

Source files
------------

// File: rtl/ara_pkg.sv
// ara_pkg: shared types for the accelerator datapath.
//   accel_op_e  - op code passed from the dispatcher to the output collector.
//   odc_state_e - state encoding of output_drain_ctrl, also exported on its
//                 state_dbg port.
//   hi_idx      - index of the highest set bit of an 8-bit mask.
package ara_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    MAC   = 3'd3,
    LOAD  = 3'd4
  } accel_op_e;

  typedef enum logic [1:0] {
    ODC_IDLE   = 2'd0,
    ODC_DRAIN  = 2'd1,
    ODC_CLEAR  = 2'd2,
    ODC_SETTLE = 2'd3
  } odc_state_e;

  localparam int ODC_NUM_REGS = 8;

  // The collector fills contiguously from bit 0, so the highest set bit is
  // the last register that holds data. Returns 0 for an empty mask.
  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/output_drain_ctrl_beat_sel.sv
// odc_beat_sel: combinational mux picking one output beat from the collector.
//   res      - all eight collector registers
//   reg_idx  - register being drained
//   beat_idx - beat within that register
//   out_data - LANES words starting at word beat_idx*LANES of res[reg_idx]
module odc_beat_sel
  import ara_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int LANES       = 8,
  parameter int BW          = 4
) (
  input  logic [ODC_NUM_REGS-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] res,
  input  logic [2:0]                                               reg_idx,
  input  logic [BW-1:0]                                            beat_idx,
  output logic [LANES-1:0][DATA_WIDTH-1:0]                         out_data
);

  int base;

  always_comb begin
    base = int'(beat_idx) * LANES;
    for (int l = 0; l < LANES; l++) begin
      out_data[l] = res[reg_idx][base + l];
    end
  end

endmodule

// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: empties the convolution output collector as a stream of
// LANES-word beats, then issues a WRITE op so the collector clears.
//   clk, rst           - clock, asynchronous active-high reset
//   op_in / op_out     - dispatcher op in, op forwarded to the collector
//   flush_req          - pulse: drain a partially filled collector
//   res, res_valid     - collector registers and their per-register valids
//   full_flag          - collector full, starts a drain
//   adder_stall        - holds the adder tree (and therefore res) frozen
//   out_data/out_valid/out_ready/out_last - beat stream. A beat moves on a
//                        cycle where out_valid & out_ready; while out_valid &
//                        !out_ready, out_data and out_last hold steady.
//   busy, done         - not idle / one-cycle completion pulse
//   stall_cnt          - cycles with out_valid & !out_ready (saturating)
//   state_dbg          - current FSM state
// Build option: ODC_PERF_CNT_EN enables stall_cnt; otherwise it reads 0.
module output_drain_ctrl
  import ara_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int LANES       = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  accel_op_e                                                op_in,
  input  logic                                                     flush_req,
  input  logic [ODC_NUM_REGS-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] res,
  input  logic [7:0]                                               res_valid,
  input  logic                                                     full_flag,
  output accel_op_e                                                op_out,
  output logic                                                     adder_stall,
  output logic [LANES-1:0][DATA_WIDTH-1:0]                         out_data,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic                                                     out_last,
  output logic                                                     busy,
  output logic                                                     done,
  output logic [31:0]                                              stall_cnt,
  output odc_state_e                                               state_dbg
);

  localparam int BEATS = DATA_OF_SET / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  odc_state_e    state_q, state_d;
  logic [2:0]    reg_idx_q, last_reg_q;
  logic [BW-1:0] beat_idx_q;
  logic          start_drain, xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ODC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    op_out      = NONE;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    start_drain = 1'b0;
    unique case (state_q)
      ODC_IDLE: begin
        op_out = op_in;
        if (full_flag || (flush_req && (res_valid != 8'd0))) begin
          start_drain = 1'b1;
          state_d     = ODC_DRAIN;
        end else if (flush_req) begin
          state_d = ODC_CLEAR;
        end
      end
      ODC_DRAIN: begin
        // All outputs here decode registered state/indices only, so out_ready
        // never reaches out_valid combinationally.
        out_valid = 1'b1;
        out_last  = (reg_idx_q == last_reg_q) && (beat_idx_q == BEAT_LAST);
        if (out_ready && out_last) state_d = ODC_CLEAR;
      end
      ODC_CLEAR: begin
        op_out  = WRITE;
        state_d = ODC_SETTLE;
      end
      ODC_SETTLE: begin
        done    = 1'b1;
        state_d = ODC_IDLE;
      end
      default: state_d = ODC_IDLE;
    endcase
  end

  assign xfer        = out_valid & out_ready;
  assign busy        = (state_q != ODC_IDLE);
  assign adder_stall = busy | full_flag;
  assign state_dbg   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_idx_q  <= 3'd0;
      beat_idx_q <= '0;
      last_reg_q <= 3'd0;
    end else if (start_drain) begin
      reg_idx_q  <= 3'd0;
      beat_idx_q <= '0;
      last_reg_q <= hi_idx(res_valid);
    end else if (xfer) begin
      if (beat_idx_q == BEAT_LAST) begin
        beat_idx_q <= '0;
        reg_idx_q  <= reg_idx_q + 3'd1;
      end else begin
        beat_idx_q <= beat_idx_q + BW'(1);
      end
    end
  end

  odc_beat_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_OF_SET(DATA_OF_SET),
    .LANES      (LANES),
    .BW         (BW)
  ) u_beat_sel (
    .res     (res),
    .reg_idx (reg_idx_q),
    .beat_idx(beat_idx_q),
    .out_data(out_data)
  );

`ifdef ODC_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_output_drain_ctrl.sv
module tb_output_drain_ctrl;
  import ara_pkg::*;

  localparam int DW = 32;
  localparam int DS = 128;
  localparam int LN = 8;
  localparam int BPR = DS / LN;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  accel_op_e                     op_in = NONE;
  logic                          flush_req = 1'b0;
  logic [7:0][DS-1:0][DW-1:0]    res;
  logic [7:0]                    res_valid = 8'h00;
  logic                          full_flag = 1'b0;
  accel_op_e                     op_out;
  logic                          adder_stall;
  logic [LN-1:0][DW-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic                          out_last;
  logic                          busy;
  logic                          done;
  logic [31:0]                   stall_cnt;
  odc_state_e                    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_stall = 32'd0;

  output_drain_ctrl #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .flush_req(flush_req), .res(res),
    .res_valid(res_valid), .full_flag(full_flag), .op_out(op_out),
    .adder_stall(adder_stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, out_last, done, busy, adder_stall} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b l=%b d=%b b=%b s=%b, want all 0",
               out_valid, out_last, done, busy, adder_stall);
    end
    n_checks++;
    if (op_out !== NONE) begin
      n_fail++;
      $display("FAIL reset_op: got %0d want %0d", op_out, NONE);
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  // Called at the sample point of the cycle right after the triggering edge.
  // Checks every beat against the res[i][w] = i*256+w pattern, counts
  // transfers, then checks the CLEAR / SETTLE / IDLE tail. With abort_at >= 0
  // it returns as soon as beat abort_at is presented.
  task automatic run_drain(input string name, input int exp_beats,
                           input bit toggle, input int abort_at);
    int k = 0;
    int cyc = 0;
    logic [LN-1:0][DW-1:0] exp_beat;
    out_ready = toggle ? 1'b0 : 1'b1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first_valid: got %b want 1", name, out_valid);
    end
    while (k < exp_beats && cyc < 1000) begin
      if (out_valid !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_valid_drop: beat %0d got out_valid=%b want 1", name, k, out_valid);
        break;
      end
      for (int l = 0; l < LN; l++)
        exp_beat[l] = 32'((k / BPR) * 256 + (k % BPR) * LN + l);
      n_checks++;
      if (out_data !== exp_beat) begin
        n_fail++;
        $display("FAIL %s_data: beat %0d got w0=%0d want w0=%0d", name, k, out_data[0], exp_beat[0]);
      end
      n_checks++;
      if (out_last !== (k == exp_beats - 1)) begin
        n_fail++;
        $display("FAIL %s_last: beat %0d got %b want %b", name, k, out_last, (k == exp_beats - 1));
      end
      n_checks++;
      if (adder_stall !== 1'b1 || op_out !== NONE || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_gating: beat %0d got stall=%b op=%0d busy=%b want 1,%0d,1",
                 name, k, adder_stall, op_out, busy, NONE);
      end
      if (abort_at >= 0 && k == abort_at) return;
      if (out_ready) k++;
      else exp_stall++;
      step();
      cyc++;
      if (toggle) out_ready = ~out_ready;
    end
    n_checks++;
    if (k !== exp_beats) begin
      n_fail++;
      $display("FAIL %s_beat_count: got %0d want %0d", name, k, exp_beats);
    end
    n_checks++;
    if (out_valid !== 1'b0 || op_out !== WRITE || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_clear: got v=%b op=%0d done=%b want 0,%0d,0", name, out_valid, op_out, done, WRITE);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || op_out !== NONE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_settle: got done=%b op=%0d busy=%b want 1,%0d,1", name, done, op_out, busy, NONE);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got done=%b busy=%b want 0,0", name, done, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic trigger_full();
    res_valid = 8'hFF;
    full_flag = 1'b1;
    step();
    // Collector would drop full only after the clear; dropping it now must
    // not disturb the drain.
    full_flag = 1'b0;
  endtask

  task automatic test_full_drain();
    op_in = WRITE;  // must not leak through while draining
    trigger_full();
    run_drain("full", 128, 1'b0, -1);
    op_in = NONE;
  endtask

  task automatic test_op_gating();
    op_in = READ;
    #1;
    n_checks++;
    if (op_out !== READ) begin
      n_fail++;
      $display("FAIL idle_op_read: got %0d want %0d", op_out, READ);
    end
    op_in = WRITE;
    #1;
    n_checks++;
    if (op_out !== WRITE) begin
      n_fail++;
      $display("FAIL idle_op_write: got %0d want %0d", op_out, WRITE);
    end
    op_in = NONE;
    step();
  endtask

  task automatic test_partial_flush();
    res_valid = 8'h07;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    run_drain("partial", 48, 1'b0, -1);
  endtask

  task automatic test_empty_flush();
    res_valid = 8'h00;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || op_out !== WRITE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_clear: got v=%b op=%0d busy=%b want 0,%0d,1", out_valid, op_out, busy, WRITE);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: got done=%b v=%b want 1,0", done, out_valid);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_idle: got busy=%b done=%b want 0,0", busy, done);
    end
  endtask

  task automatic test_backpressure();
    trigger_full();
    run_drain("bp", 128, 1'b1, -1);
`ifndef ODC_PERF_CNT_EN
    exp_stall = 32'd0;
`endif
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid_drain();
    trigger_full();
    run_drain("abort", 128, 1'b0, 40);
    rst = 1'b1;
    #1;
    exp_stall = 32'd0;
    n_checks++;
    if ({out_valid, out_last, done, busy, adder_stall} !== 5'b0 || op_out !== NONE) begin
      n_fail++;
      $display("FAIL abort_reset_outputs: got v=%b l=%b d=%b b=%b s=%b op=%0d, want 0s and %0d",
               out_valid, out_last, done, busy, adder_stall, op_out, NONE);
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_stall_cnt: got %0d want 0", stall_cnt);
    end
    step();
    rst = 1'b0;
    step();
    trigger_full();
    run_drain("restart", 128, 1'b0, -1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < DS; w++)
        res[i][w] = 32'(i * 256 + w);
    rst = 1'b1;
    #2;
    test_reset();
    step();
    step();
    rst = 1'b0;
    step();
    test_full_drain();
    test_op_gating();
    test_partial_flush();
    test_empty_flush();
    test_backpressure();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
